bidir_serializer: RTL

- Parallel-in, serial-out transmitter that produces the serial bitstream consumed by the team's N-bit bidirectional shift register and serial receivers.
- Accepts an N-bit word over a valid/ready handshake and shifts it out one bit per clock, MSB-first or LSB-first as selected per word.
- Marks each frame with start/end strobes and supports back-to-back words with no idle gap.

---
 rtl/bidir_serializer_pkg.sv | 15 +
 rtl/bidir_serializer_bit_counter.sv | 25 ++
 rtl/bidir_serializer.sv | 76 +++++++
 3 files changed

// File: rtl/bidir_serializer_pkg.sv
// Shared types and helpers for the bidirectional serializer.
// Holds the FSM state encoding and the bit-counter width calculation.
package bidir_serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Counter width is max(1, clog2(n)) so N=1 still gets a one-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bidir_serializer_bit_counter.sv
// Frame bit counter: clears on reset or load, advances on inc.
// last flags the final bit position of the frame.
module bit_counter #(
   parameter int WIDTH = 3,
   parameter int MAX   = 7
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             last
);

   always_ff @(posedge clk) begin
      if (clr || load) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   assign last = (count == WIDTH'(MAX));

endmodule

// File: rtl/bidir_serializer.sv
// Parallel-in, serial-out transmitter with per-word MSB/LSB-first selection.
// Frames are marked with start/end strobes and may run back-to-back without gaps.
module bidir_serializer
   import bidir_serializer_pkg::*;
#(
   parameter int   N        = 8,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [N-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   input  logic         L_R,
   output logic         sout,
   output logic         sout_valid,
   output logic         frame_start,
   output logic         frame_end,
   output logic         busy
);

   localparam int CNT_W = cnt_width(N);

   state_t           state;
   logic [N-1:0]     shreg;
   logic             dir;
   logic [CNT_W-1:0] count;
   logic             last;
   logic             accept;
   logic             shifting;

   assign shifting = (state == ST_SHIFT);

   // Handshake: a word transfers on any rising edge where din_valid && din_ready;
   // din_ready rises on the last bit of a frame so the next word follows with no gap.
   assign din_ready = !clr && (!shifting || last);
   assign accept    = din_valid && din_ready;

   bit_counter #(
      .WIDTH (CNT_W),
      .MAX   (N - 1)
   ) u_bit_counter (
      .clk   (clk),
      .clr   (clr),
      .load  (accept),
      .inc   (shifting && !last),
      .count (count),
      .last  (last)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= ST_IDLE;
         shreg <= '0;
         dir   <= 1'b0;
      end else if (accept) begin
         state <= ST_SHIFT;
         shreg <= din;
         dir   <= L_R;
      end else if (shifting) begin
         if (last) begin
            state <= ST_IDLE;
         end else begin
            // Move the next bit toward whichever end drives sout; zero fills behind.
            shreg <= dir ? (shreg << 1) : (shreg >> 1);
         end
      end
   end

   assign sout        = shifting ? (dir ? shreg[N-1] : shreg[0]) : IDLE_LVL;
   assign sout_valid  = shifting;
   assign frame_start = shifting && (count == '0);
   assign frame_end   = shifting && last;
   assign busy        = shifting;

endmodule
